// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-byte sequential adder: state encoding,
// default operand length and the signed-overflow rule.
package mp_add_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int MAX_BYTES_DEF = 16;

   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
      return (a_msb == b_msb) && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/cla8_core.sv
// Combinational 8-bit carry-lookahead adder; every carry is formed directly
// from generate/propagate terms and cin rather than rippling bit to bit.
module cla8_core (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;
   logic       term;
   logic       prod;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      term = 1'b0;
      prod = 1'b1;
      c[0] = cin;
      for (int i = 0; i < 8; i++) begin
         term = 1'b0;
         prod = 1'b1;
         for (int j = i; j >= 0; j--) begin
            term = term | (g[j] & prod);
            prod = prod & p[j];
         end
         c[i+1] = term | (prod & cin);
      end
      sum  = p ^ c[7:0];
      cout = c[8];
   end

endmodule

// File: rtl/mp_add_seq.sv
// Byte-serial multi-byte adder, LSB first, with a single registered output
// stage, carry chaining across bytes and framing/length error detection.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the first (least-significant) byte of an operand
// BUSY  | inside an operand; carry_q holds the carry of the previous byte
module mp_add_seq
   import mp_add_pkg::*;
#(
   parameter int MAX_BYTES = MAX_BYTES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   input  logic       in_first,
   input  logic       in_last,
   input  logic       cin,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_sum,
   output logic       out_first,
   output logic       out_last,
   output logic       out_cout,
   output logic       out_ovf,
   output logic       err
);

   localparam int CW = $clog2(MAX_BYTES);
   typedef logic [CW-1:0] left_t;

   state_t     state;
   state_t     state_nxt;
   logic       carry_q;
   logic       carry_nxt;
   left_t      left_q;
   left_t      left_nxt;
   logic       accept;
   logic       first_eff;
   logic       last_eff;
   logic       force_last;
   logic       proto_err;
   logic       err_nxt;
   logic       cy;
   logic       c;
   logic [7:0] sum;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   cla8_core u_cla (
      .a    (in_a),
      .b    (in_b),
      .cin  (cy),
      .sum  (sum),
      .cout (c)
   );

   // left_q counts down the bytes still allowed in the current operand;
   // reaching 1 on a non-first byte means this byte is the MAX_BYTES-th.
   always_comb begin
      state_nxt  = state;
      carry_nxt  = carry_q;
      left_nxt   = left_q;
      err_nxt    = 1'b0;
      first_eff  = (state == IDLE) || in_first;
      proto_err  = (state == IDLE) ? !in_first : in_first;
      force_last = !first_eff && (left_q == left_t'(1)) && !in_last;
      last_eff   = in_last || force_last;
      cy         = first_eff ? cin : carry_q;
      if (accept) begin
         carry_nxt = c;
         err_nxt   = proto_err || force_last;
         left_nxt  = first_eff ? left_t'(MAX_BYTES - 1) : left_q - 1'b1;
         state_nxt = last_eff ? IDLE : BUSY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         carry_q <= 1'b0;
         left_q  <= '0;
      end else begin
         state   <= state_nxt;
         carry_q <= carry_nxt;
         left_q  <= left_nxt;
      end
   end

   // A new accept always wins over a same-cycle drain so the stage never bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= err_nxt;
         if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_first <= first_eff;
            out_last  <= last_eff;
            out_cout  <= last_eff ? c : 1'b0;
            out_ovf   <= last_eff ? add_ovf(in_a[7], in_b[7], sum[7]) : 1'b0;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16, maximum bytes per multi-byte operand (2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand byte pair presented.
REQ-005 SHALL have port in_ready  output  1  block accepts the pair this cycle.
REQ-006 SHALL have ports in_a, in_b  input  8  operand bytes, least-significant byte first.
REQ-007 SHALL have port in_first  input  1  byte is the LSB of a new operand.
REQ-008 SHALL have port in_last  input  1  byte is the MSB of the operand.
REQ-009 SHALL have port cin  input  1  carry-in; sampled only on a first byte.
REQ-010 SHALL have ports out_valid  output  1 and out_ready  input  1  result handshake.
REQ-011 SHALL have port out_sum  output  8  sum byte.
REQ-012 SHALL have ports out_first, out_last  output  1  framing copied from the accepted byte.
REQ-013 SHALL have port out_cout  output  1  final carry-out; meaningful only when out_last=1, else 0.
REQ-014 SHALL have port out_ovf  output  1  signed overflow of the whole operand; meaningful only when out_last=1, else 0.
REQ-015 SHALL have port err  output  1  one-cycle protocol-error pulse.

Function
REQ-016 SHALL transfer on input when in_valid and in_ready are both 1, and on output when out_valid and out_ready are both 1.
REQ-017 SHALL set in_ready = !out_valid || out_ready (single output register, combinational ready, no bubble under full throughput).
REQ-018 SHALL compute {c, out_sum} = in_a + in_b + cy, with cy = cin on a first byte and cy = carry_q otherwise; latency one cycle from input transfer to out_valid.
REQ-019 SHALL update carry_q to c on every accepted byte.
REQ-020 SHALL implement states IDLE (awaiting first byte) and BUSY (inside operand): IDLE->BUSY on accepted first byte with in_last=0; BUSY->IDLE on accepted last byte; a first+last byte stays IDLE.
REQ-021 SHALL, in IDLE, treat a byte with in_first=0 as a first byte (use cin), output out_first=1, and pulse err.
REQ-022 SHALL, in BUSY, treat a byte with in_first=1 as the start of a new operand (discard carry_q, use cin), and pulse err.
REQ-023 SHALL count accepted bytes per operand; if byte MAX_BYTES arrives with in_last=0, force out_last=1, return to IDLE, and pulse err.
REQ-024 SHALL set out_cout = c and out_ovf = (in_a[7]==in_b[7]) && (out_sum[7]!=in_a[7]) on the last byte.
REQ-025 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-026 SHALL allow a new input transfer in the same cycle as an output transfer (simultaneous events), with the register taking the new result.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set state IDLE, carry_q 0, byte counter 0, out_valid 0, out_sum 0, out_first 0, out_last 0, out_cout 0, out_ovf 0, err 0.
REQ-028 SHALL drop any partial operand or held result on reset mid-operation; in_ready SHALL be 1 on the first cycle after reset.

Structure
REQ-029 SHALL place the state encoding (IDLE, BUSY) and the MAX_BYTES default in a shared package, mp_add_pkg.
REQ-030 SHALL instantiate one combinational 8-bit carry-lookahead sub-module, cla8_core (a, b, cin -> sum, cout), for the byte add.

Verification
REQ-031 SHALL cover single byte first+last, a=0x00, b=0x03, cin=0 -> sum 0x03, cout 0, ovf 0, one cycle latency.
REQ-032 SHALL cover 2-byte 0x00FF + 0x0001, cin=0 -> bytes 0x00 then 0x01, cout 0; 0xFFFF + 0x0001 -> 0x00, 0x00, cout 1.
REQ-033 SHALL cover signed overflow, single byte 0x73 + 0x13 -> sum 0x86, ovf 1, cout 0; 0xF3 + 0xF3, cin=1 -> 0xE7, cout 1, ovf 0.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles mid-operand -> in_ready 0, outputs held, no byte lost or duplicated.
REQ-035 SHALL cover protocol errors: in_first=1 mid-operand -> err pulse and cin used; MAX_BYTES bytes without last -> forced out_last, err pulse.
REQ-036 SHALL cover reset mid-operand after byte 2 -> out_valid 0, next byte handled as first (err pulse if in_first=0).
